// File: rtl/npn4_pkg.sv
// Shared types for the 4-input NPN truth-table self-check slice.
package npn4_pkg;
  localparam int N_IN = 4;
  localparam int TT_W = 16;

  typedef logic [TT_W-1:0] tt_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_st_t;
endpackage

// File: rtl/npn4_tt_compare.sv
// Compares a captured truth table against its golden table.
// Latency: combinational.
// Backpressure: none.
module npn4_tt_compare
  import npn4_pkg::*;
(
  input  tt_t        a,
  input  tt_t        b,
  output logic       eq,
  output logic [4:0] pop,
  output logic [3:0] low_idx
);

  tt_t diff;
  assign diff = a ^ b;

  always_comb begin
    eq      = (diff == '0);
    pop     = 5'd0;
    low_idx = 4'd0;
    for (int i = 0; i < TT_W; i++) begin
      if (diff[i]) pop = pop + 5'd1;
    end
    // Scan downward so the last hit written is the lowest differing minterm.
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff[i]) low_idx = 4'(i);
    end
  end

endmodule

// File: rtl/npn4_tt_sweep.sv
// Walks minterms 0..15 on x0..x3, captures y0 into a truth table, checks it.
// Latency: done 16*(SETTLE_CYCLES+1) edges after the accept edge.
// Backpressure: none; start outside IDLE is dropped, not queued.
module npn4_tt_sweep
  import npn4_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  tt_t        expected_tt,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  input  logic       y0,
  output logic       busy,
  output logic       done,
  output tt_t        tt_out,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic [3:0] first_mis
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

  sweep_st_t        st_q, st_d;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  tt_t              exp_q;
  tt_t              tt_q, tt_d;
  logic             sample;
  logic             cmp_eq;
  logic [4:0]       cmp_pop;
  logic [3:0]       cmp_low;

  assign sample = (st_q == RUN) && (cnt_q == CNT_LAST);

  // Results are taken from the table including the bit sampled on the final edge.
  always_comb begin
    tt_d = tt_q;
    if (sample) tt_d[idx_q] = y0;
  end

  npn4_tt_compare u_cmp (
    .a       (tt_d),
    .b       (exp_q),
    .eq      (cmp_eq),
    .pop     (cmp_pop),
    .low_idx (cmp_low)
  );

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (start) st_d = RUN;
      RUN:     if (sample && idx_q == 4'hF) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= '0;
      exp_q        <= '0;
      tt_q         <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= 5'd0;
      first_mis    <= 4'd0;
    end else begin
      st_q <= st_d;
      case (st_q)
        IDLE: begin
          if (start) begin
            idx_q <= 4'd0;
            cnt_q <= '0;
            exp_q <= expected_tt;
            tt_q  <= '0;
          end
        end
        RUN: begin
          tt_q <= tt_d;
          if (sample) begin
            cnt_q <= '0;
            if (idx_q != 4'hF) idx_q <= idx_q + 4'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (st_d == DONE) begin
            pass         <= cmp_eq;
            mismatch_cnt <= cmp_pop;
            first_mis    <= cmp_low;
          end
        end
        DONE:    idx_q <= 4'd0;
        default: idx_q <= 4'd0;
      endcase
    end
  end

  // idx is zero outside RUN, so it doubles as the registered minterm drive.
  assign {x3, x2, x1, x0} = idx_q;
  assign busy   = (st_q == RUN);
  assign done   = (st_q == DONE);
  assign tt_out = tt_q;

endmodule

// File: tb/tb_npn4_tt_sweep.sv
// Scoreboard bench for npn4_tt_sweep at SETTLE_CYCLES of 1, 3 and 0.
module tb_npn4_tt_sweep;
  import npn4_pkg::*;

  typedef struct {
    int         dut;
    tt_t        tt;
    logic       pass;
    logic [4:0] cnt;
    logic [3:0] fm;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  tt_t  exp_tt = '0;
  int   fsel = 0;

  wire [3:0] xa, xb, xc;
  logic      ya, yb, yc;
  logic      busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic      pass_a, pass_b, pass_c;
  tt_t       tt_a, tt_b, tt_c;
  logic [4:0] mc_a, mc_b, mc_c;
  logic [3:0] fm_a, fm_b, fm_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    case (fsel)
      0:       ya = xa[0];
      1:       ya = xa[3];
      default: ya = 1'b0;
    endcase
  end

  // Function under test with one register stage on its output.
  initial begin yb = 1'b0; yc = 1'b0; end
  always @(posedge clk) begin
    yb <= xb[0] ^ xb[1];
    yc <= xc[0] ^ xc[1];
  end

  npn4_tt_sweep #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected_tt(exp_tt),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .y0(ya),
    .busy(busy_a), .done(done_a), .tt_out(tt_a), .pass(pass_a),
    .mismatch_cnt(mc_a), .first_mis(fm_a)
  );

  npn4_tt_sweep #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected_tt(exp_tt),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .y0(yb),
    .busy(busy_b), .done(done_b), .tt_out(tt_b), .pass(pass_b),
    .mismatch_cnt(mc_b), .first_mis(fm_b)
  );

  npn4_tt_sweep #(.SETTLE_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .expected_tt(exp_tt),
    .x0(xc[0]), .x1(xc[1]), .x2(xc[2]), .x3(xc[3]), .y0(yc),
    .busy(busy_c), .done(done_c), .tt_out(tt_c), .pass(pass_c),
    .mismatch_cnt(mc_c), .first_mis(fm_c)
  );

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic pop_check(int d, tt_t tt, logic p, logic [4:0] mc, logic [3:0] fm);
    exp_t e;
    check_eq("sb_pending_at_done", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("done_dut", d, e.dut);
      check_eq("done_cycle", cyc, e.done_cyc);
      check_eq("tt_out", tt, e.tt);
      check_eq("pass", p, e.pass);
      check_eq("mismatch_cnt", mc, e.cnt);
      check_eq("first_mis", fm, e.fm);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("busy_done_excl_a", busy_a & done_a, 0);
      check_eq("busy_done_excl_b", busy_b & done_b, 0);
      check_eq("busy_done_excl_c", busy_c & done_c, 0);
    end
    if (done_a) pop_check(0, tt_a, pass_a, mc_a, fm_a);
    if (done_b) pop_check(1, tt_b, pass_b, mc_b, fm_b);
    if (done_c) pop_check(2, tt_c, pass_c, mc_c, fm_c);
  end

  task automatic set_start(int d, logic v);
    case (d)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic push(int d, tt_t tt, logic p, logic [4:0] mc, logic [3:0] fm, int done_cyc);
    exp_t e;
    e.dut = d; e.tt = tt; e.pass = p; e.cnt = mc; e.fm = fm; e.done_cyc = done_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  // Called at a negedge: accept lands on the next edge, done 16*(S+1) edges later.
  task automatic sweep(int d, int s, tt_t golden, tt_t tt, logic p, logic [4:0] mc, logic [3:0] fm);
    exp_tt = golden;
    set_start(d, 1'b1);
    push(d, tt, p, mc, fm, cyc + 1 + 16 * (s + 1));
    @(negedge clk);
    set_start(d, 1'b0);
    wait_drain(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int i;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_x", xa, 0);
    check_eq("rst_tt", tt_a, 0);
    check_eq("rst_pass", pass_a, 0);
    check_eq("rst_mc", mc_a, 0);
    check_eq("rst_fm", fm_a, 0);
    rst = 1'b0;
    @(negedge clk);

    fsel = 0;
    sweep(0, 1, 16'hAAAA, 16'hAAAA, 1'b1, 5'd0, 4'd0);
    repeat (5) @(negedge clk);
    check_eq("pass_held", pass_a, 1);
    check_eq("tt_held", tt_a, 16'hAAAA);
    check_eq("x_idle", xa, 0);

    fsel = 1;
    sweep(0, 1, 16'hAAAA, 16'hFF00, 1'b0, 5'd8, 4'd1);
    fsel = 2;
    sweep(0, 1, 16'h0001, 16'h0000, 1'b0, 5'd1, 4'd0);

    // Reset in the middle of a sweep.
    fsel = 0;
    exp_tt = 16'hAAAA;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (i = 0; i < 100 && xa != 4'd7; i++) @(negedge clk);
    check_eq("reach_idx7", xa, 7);
    check_eq("busy_mid", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", busy_a, 0);
    check_eq("midrst_x", xa, 0);
    check_eq("midrst_tt", tt_a, 0);
    check_eq("midrst_done", done_a, 0);
    repeat (40) @(negedge clk);
    sweep(0, 1, 16'hAAAA, 16'hAAAA, 1'b1, 5'd0, 4'd0);

    // start held high: back-to-back sweeps every 34 cycles.
    exp_tt = 16'hAAAA;
    base = cyc + 1 + 32;
    for (int k = 0; k < 3; k++) push(0, 16'hAAAA, 1'b1, 5'd0, 4'd0, base + 34 * k);
    start_a = 1'b1;
    wait_drain(400);
    start_a = 1'b0;
    repeat (40) @(negedge clk);

    // Extra start pulses during RUN and DONE are ignored.
    start_a = 1'b1;
    push(0, 16'hAAAA, 1'b1, 5'd0, 4'd0, cyc + 1 + 32);
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (i = 0; i < 100 && !done_a; i++) @(negedge clk);
    check_eq("pulse_done_seen", done_a, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("pulse_no_restart", busy_a, 0);
    wait_drain(1);

    // Registered function under test at S=3 (settles) and S=0 (one minterm late).
    sweep(1, 3, 16'h6666, 16'h6666, 1'b1, 5'd0, 4'd0);
    sweep(2, 0, 16'h6666, 16'hCCCC, 1'b0, 5'd8, 4'd1);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
